// File: rtl/hk_arb_pkg.sv
// Shared types and constants for the housekeeping bus arbiter.
package hk_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } hk_arb_state_e;

  // Default transaction timeout in cycles
  localparam int unsigned TmoDefault = 255;

  // Width of the timeout counter
  localparam int unsigned CntWidth = 16;

endpackage

// File: rtl/hk_arb_req_slot.sv
// One-deep pending request slot for a single bus master.
// A strobe is only captured while the slot is empty; a write wins over a read.
module hk_arb_req_slot
  import hk_arb_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          wen_i,
  input  logic          ren_i,
  input  logic          clr_i,
  output logic          pend_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] wdata_o,
  output logic          we_o
);

  logic          pend_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;

  // Capture a new request when empty; release it when the arbiter completes it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (clr_i) begin
      pend_q <= 1'b0;
    end else if (!pend_q && (wen_i || ren_i)) begin
      pend_q  <= 1'b1;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      we_q    <= wen_i;
    end
  end

  assign pend_o  = pend_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign we_o    = we_q;

endmodule

// File: rtl/red_pitaya_hk_arb.sv
// Two-master to one-slave housekeeping bus arbiter with round-robin
// grant, registered slave strobes and a per-transaction timeout.
module red_pitaya_hk_arb
  import hk_arb_pkg::*;
#(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned TMO = TmoDefault
) (
  input  logic          clk_i,
  input  logic          rst_i,
  // master 0
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  input  logic          m0_wen_i,
  input  logic          m0_ren_i,
  output logic [DW-1:0] m0_rdata_o,
  output logic          m0_err_o,
  output logic          m0_ack_o,
  // master 1
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  input  logic          m1_wen_i,
  input  logic          m1_ren_i,
  output logic [DW-1:0] m1_rdata_o,
  output logic          m1_err_o,
  output logic          m1_ack_o,
  // slave
  output logic [AW-1:0] s_addr_o,
  output logic [DW-1:0] s_wdata_o,
  output logic          s_wen_o,
  output logic          s_ren_o,
  input  logic [DW-1:0] s_rdata_i,
  input  logic          s_err_i,
  input  logic          s_ack_i,
  output logic [1:0]    grant_o
);

  logic [1:0]    pend;
  logic [1:0]    slot_we;
  logic [1:0]    clr;
  logic [AW-1:0] slot_addr  [2];
  logic [DW-1:0] slot_wdata [2];

  hk_arb_req_slot #(.AW(AW), .DW(DW)) u_slot0 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .addr_i  (m0_addr_i),
    .wdata_i (m0_wdata_i),
    .wen_i   (m0_wen_i),
    .ren_i   (m0_ren_i),
    .clr_i   (clr[0]),
    .pend_o  (pend[0]),
    .addr_o  (slot_addr[0]),
    .wdata_o (slot_wdata[0]),
    .we_o    (slot_we[0])
  );

  hk_arb_req_slot #(.AW(AW), .DW(DW)) u_slot1 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .addr_i  (m1_addr_i),
    .wdata_i (m1_wdata_i),
    .wen_i   (m1_wen_i),
    .ren_i   (m1_ren_i),
    .clr_i   (clr[1]),
    .pend_o  (pend[1]),
    .addr_o  (slot_addr[1]),
    .wdata_o (slot_wdata[1]),
    .we_o    (slot_we[1])
  );

  hk_arb_state_e       state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                prio_q, prio_d;      // 1: master 1 wins a tie
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [AW-1:0]       s_addr_q, s_addr_d;
  logic [DW-1:0]       s_wdata_q, s_wdata_d;
  logic                s_wen_q, s_wen_d;
  logic                s_ren_q, s_ren_d;
  logic [1:0]          ack_q, ack_d;
  logic [1:0]          err_q, err_d;
  logic [DW-1:0]       rdata_q [2];
  logic [DW-1:0]       rdata_d [2];
  logic                sel;
  logic                idx;
  logic                tmo_hit;

  // Counter value during the last cycle a transaction may stay open
  assign tmo_hit = (cnt_q == CntWidth'(TMO - 1));

  // Next-state: arbitration in IDLE, strobe/ack/timeout handling in ISSUE/WAIT
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_wen_d   = 1'b0;
    s_ren_d   = 1'b0;
    ack_d     = '0;
    err_d     = '0;
    rdata_d   = rdata_q;
    clr       = '0;
    sel       = 1'b0;
    idx       = grant_q[1];
    unique case (state_q)
      IDLE: begin
        if (pend != 2'b00) begin
          sel       = (pend == 2'b11) ? prio_q : pend[1];
          grant_d   = sel ? 2'b10 : 2'b01;
          prio_d    = !sel;
          s_addr_d  = slot_addr[sel];
          s_wdata_d = slot_wdata[sel];
          s_wen_d   = slot_we[sel];
          s_ren_d   = !slot_we[sel];
          cnt_d     = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        state_d = WAIT;
        cnt_d   = cnt_q + 1'b1;
        // A real ack takes precedence over a coincident timeout
        if (s_ack_i || tmo_hit) begin
          ack_d[idx]   = 1'b1;
          err_d[idx]   = !s_ack_i || s_err_i;
          rdata_d[idx] = s_ack_i ? s_rdata_i : '0;
          clr[idx]     = 1'b1;
          grant_d      = '0;
          cnt_d        = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      prio_q     <= 1'b0;
      cnt_q      <= '0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_wen_q    <= 1'b0;
      s_ren_q    <= 1'b0;
      ack_q      <= '0;
      err_q      <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_wen_q   <= s_wen_d;
      s_ren_q   <= s_ren_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_addr_o   = s_addr_q;
  assign s_wdata_o  = s_wdata_q;
  assign s_wen_o    = s_wen_q;
  assign s_ren_o    = s_ren_q;
  assign grant_o    = grant_q;
  assign m0_ack_o   = ack_q[0];
  assign m1_ack_o   = ack_q[1];
  assign m0_err_o   = err_q[0];
  assign m1_err_o   = err_q[1];
  assign m0_rdata_o = rdata_q[0];
  assign m1_rdata_o = rdata_q[1];

endmodule

// File: tb/tb_red_pitaya_hk_arb.sv
// Directed self-checking bench for red_pitaya_hk_arb (TMO = 16).
module tb_red_pitaya_hk_arb;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] m0_addr_i = '0, m0_wdata_i = '0;
  logic        m0_wen_i = 1'b0, m0_ren_i = 1'b0;
  logic [31:0] m1_addr_i = '0, m1_wdata_i = '0;
  logic        m1_wen_i = 1'b0, m1_ren_i = 1'b0;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        m0_err_o, m0_ack_o, m1_err_o, m1_ack_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic        s_wen_o, s_ren_o;
  logic [31:0] s_rdata_i = '0;
  logic        s_err_i = 1'b0;
  logic        s_ack_i = 1'b0;
  logic [1:0]  grant_o;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Slave model state: ack one cycle after a strobe, rdata = running ack count
  logic        slave_en  = 1'b1;
  logic        ack_pipe  = 1'b0;
  logic        stray_ack = 1'b0;
  int unsigned rd_idx    = 0;

  always #5 clk_i = ~clk_i;

  red_pitaya_hk_arb #(.AW(32), .DW(32), .TMO(16)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .m0_addr_i  (m0_addr_i),
    .m0_wdata_i (m0_wdata_i),
    .m0_wen_i   (m0_wen_i),
    .m0_ren_i   (m0_ren_i),
    .m0_rdata_o (m0_rdata_o),
    .m0_err_o   (m0_err_o),
    .m0_ack_o   (m0_ack_o),
    .m1_addr_i  (m1_addr_i),
    .m1_wdata_i (m1_wdata_i),
    .m1_wen_i   (m1_wen_i),
    .m1_ren_i   (m1_ren_i),
    .m1_rdata_o (m1_rdata_o),
    .m1_err_o   (m1_err_o),
    .m1_ack_o   (m1_ack_o),
    .s_addr_o   (s_addr_o),
    .s_wdata_o  (s_wdata_o),
    .s_wen_o    (s_wen_o),
    .s_ren_o    (s_ren_o),
    .s_rdata_i  (s_rdata_i),
    .s_err_i    (s_err_i),
    .s_ack_i    (s_ack_i),
    .grant_o    (grant_o)
  );

  // Advance to the next falling edge and update the slave model there
  task automatic tick();
    @(negedge clk_i);
    s_ack_i = (slave_en && ack_pipe) || stray_ack;
    if (slave_en && ack_pipe) begin
      s_rdata_i = 32'(rd_idx);
      rd_idx++;
    end else begin
      s_rdata_i = 32'hFFFF_FFFF;
    end
    ack_pipe = s_wen_o | s_ren_o;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_swen", 32'(s_wen_o), 32'h0);
    chk("rst_ack0", 32'(m0_ack_o), 32'h0);
    chk("rst_rdata0", m0_rdata_o, 32'h0);

    // m0 write 0x30/0x80, strobe on the first edge after reset release
    rst_i = 1'b0;
    m0_addr_i = 32'h30; m0_wdata_i = 32'h80; m0_wen_i = 1'b1;
    tick(); m0_wen_i = 1'b0;
    chk("w_idle_grant", 32'(grant_o), 32'h0);
    tick();
    chk("w_swen", 32'(s_wen_o), 32'h1);
    chk("w_sren", 32'(s_ren_o), 32'h0);
    chk("w_saddr", s_addr_o, 32'h30);
    chk("w_swdata", s_wdata_o, 32'h80);
    chk("w_grant", 32'(grant_o), 32'h1);
    tick();
    chk("w_swen_pulse", 32'(s_wen_o), 32'h0);
    chk("w_ack_early", 32'(m0_ack_o), 32'h0);
    tick();
    chk("w_ack0", 32'(m0_ack_o), 32'h1);
    chk("w_err0", 32'(m0_err_o), 32'h0);
    chk("w_ack1", 32'(m1_ack_o), 32'h0);
    chk("w_grant_idle", 32'(grant_o), 32'h0);
    tick();
    chk("w_ack0_once", 32'(m0_ack_o), 32'h0);

    // Simultaneous reads after reset: m0 first (rdata 1), then m1 (rdata 2)
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    m0_addr_i = 32'h40; m0_ren_i = 1'b1;
    m1_addr_i = 32'h44; m1_ren_i = 1'b1;
    tick(); m0_ren_i = 1'b0; m1_ren_i = 1'b0;
    tick();
    chk("rr_grant_m0", 32'(grant_o), 32'h1);
    chk("rr_sren", 32'(s_ren_o), 32'h1);
    chk("rr_saddr0", s_addr_o, 32'h40);
    tick();
    tick();
    chk("rr_ack0", 32'(m0_ack_o), 32'h1);
    chk("rr_rdata0", m0_rdata_o, 32'h1);
    chk("rr_ack1_idle", 32'(m1_ack_o), 32'h0);
    tick();
    chk("rr_grant_m1", 32'(grant_o), 32'h2);
    chk("rr_saddr1", s_addr_o, 32'h44);
    tick();
    tick();
    chk("rr_ack1", 32'(m1_ack_o), 32'h1);
    chk("rr_rdata1", m1_rdata_o, 32'h2);
    chk("rr_ack0_quiet", 32'(m0_ack_o), 32'h0);
    chk("rr_rdata0_hold", m0_rdata_o, 32'h1);

    // m1 read with no slave ack: timeout error 16 cycles after ISSUE
    slave_en = 1'b0;
    tick();
    m1_addr_i = 32'h50; m1_ren_i = 1'b1;
    tick(); m1_ren_i = 1'b0;
    tick();
    chk("to_grant", 32'(grant_o), 32'h2);
    for (int i = 1; i <= 15; i++) tick();
    chk("to_ack_early", 32'(m1_ack_o), 32'h0);
    chk("to_grant_hold", 32'(grant_o), 32'h2);
    tick();
    chk("to_ack1", 32'(m1_ack_o), 32'h1);
    chk("to_err1", 32'(m1_err_o), 32'h1);
    chk("to_rdata1", m1_rdata_o, 32'h0);
    chk("to_grant_idle", 32'(grant_o), 32'h0);
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    tick();
    chk("stray_ack1", 32'(m1_ack_o), 32'h0);
    chk("stray_ack0", 32'(m0_ack_o), 32'h0);
    chk("stray_grant", 32'(grant_o), 32'h0);

    // Back-to-back m0 requests against a pending m1: strict alternation
    slave_en = 1'b1;
    m0_addr_i = 32'h60; m0_ren_i = 1'b1;
    m1_addr_i = 32'h70; m1_ren_i = 1'b1;
    tick(); m0_ren_i = 1'b0; m1_ren_i = 1'b0;
    tick();
    chk("alt1_grant", 32'(grant_o), 32'h1);
    tick();
    tick();
    chk("alt1_ack0", 32'(m0_ack_o), 32'h1);
    m0_addr_i = 32'h64; m0_ren_i = 1'b1;
    tick(); m0_ren_i = 1'b0;
    chk("alt2_grant", 32'(grant_o), 32'h2);
    chk("alt2_saddr", s_addr_o, 32'h70);
    tick();
    tick();
    chk("alt2_ack1", 32'(m1_ack_o), 32'h1);
    tick();
    chk("alt3_grant", 32'(grant_o), 32'h1);
    chk("alt3_saddr", s_addr_o, 32'h64);
    tick();
    tick();
    chk("alt3_ack0", 32'(m0_ack_o), 32'h1);
    m0_addr_i = 32'h68; m0_ren_i = 1'b1;
    m1_addr_i = 32'h74; m1_ren_i = 1'b1;
    tick(); m0_ren_i = 1'b0; m1_ren_i = 1'b0;
    tick();
    chk("alt4_grant_m1", 32'(grant_o), 32'h2);
    chk("alt4_saddr", s_addr_o, 32'h74);
    tick();
    tick();
    chk("alt4_ack1", 32'(m1_ack_o), 32'h1);
    tick();
    chk("alt5_grant_m0", 32'(grant_o), 32'h1);
    chk("alt5_saddr", s_addr_o, 32'h68);
    tick();
    tick();
    chk("alt5_ack0", 32'(m0_ack_o), 32'h1);
    chk("alt5_rdata0", m0_rdata_o, 32'h7);

    // Reset asserted while in WAIT; strobe during reset is discarded
    slave_en = 1'b0;
    tick();
    m0_addr_i = 32'h90; m0_ren_i = 1'b1;
    tick(); m0_ren_i = 1'b0;
    tick();
    tick();
    chk("rw_grant_wait", 32'(grant_o), 32'h1);
    #1;
    rst_i = 1'b1;
    m0_wen_i = 1'b1;
    #1;
    chk("rw_async_grant", 32'(grant_o), 32'h0);
    chk("rw_async_saddr", s_addr_o, 32'h0);
    chk("rw_async_rdata0", m0_rdata_o, 32'h0);
    tick();
    m0_wen_i = 1'b0;
    rst_i = 1'b0;
    tick();
    chk("rw_no_ack", 32'(m0_ack_o), 32'h0);
    chk("rw_discard", 32'(grant_o), 32'h0);
    slave_en = 1'b1;
    ack_pipe = 1'b0;
    m1_addr_i = 32'hA0; m1_ren_i = 1'b1;
    tick(); m1_ren_i = 1'b0;
    tick();
    chk("rw_m1_grant", 32'(grant_o), 32'h2);
    chk("rw_m1_saddr", s_addr_o, 32'hA0);
    tick();
    tick();
    chk("rw_m1_ack", 32'(m1_ack_o), 32'h1);
    chk("rw_m1_err", 32'(m1_err_o), 32'h0);
    chk("rw_m1_rdata", m1_rdata_o, 32'h8);

    // wen and ren together: write only
    tick();
    m0_addr_i = 32'hB0; m0_wdata_i = 32'hA5; m0_wen_i = 1'b1; m0_ren_i = 1'b1;
    tick(); m0_wen_i = 1'b0; m0_ren_i = 1'b0;
    tick();
    chk("wr_both_swen", 32'(s_wen_o), 32'h1);
    chk("wr_both_sren", 32'(s_ren_o), 32'h0);
    chk("wr_both_wdata", s_wdata_o, 32'hA5);
    tick();
    tick();
    chk("wr_both_ack", 32'(m0_ack_o), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/red_pitaya_hk_arb.md
RED_PITAYA_HK_ARB -- requirements
Module: red_pitaya_hk_arb

Interface
REQ-001 SHALL have parameters: AW, default 32, address width; DW, default 32, data width; TMO, default 255, timeout in cycles (range 2..65535).
REQ-002 SHALL have ports clk_i, in, 1, single clock: one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port rst_i, in, 1, asynchronous active-high reset.
REQ-004 SHALL have, for each master mN (N=0,1), these ports: mN_addr_i (in, AW), mN_wdata_i (in, DW), mN_wen_i (in, 1, write pulse), mN_ren_i (in, 1, read pulse).
REQ-005 SHALL have, for each master mN (N=0,1), these ports: mN_rdata_o (out, DW), mN_err_o (out, 1), mN_ack_o (out, 1).
REQ-006 SHALL have slave-side ports: s_addr_o (out, AW), s_wdata_o (out, DW), s_wen_o (out, 1), s_ren_o (out, 1).
REQ-007 SHALL have slave-side ports: s_rdata_i (in, DW), s_err_i (in, 1), s_ack_i (in, 1).
REQ-008 SHALL have port grant_o, out, 2, one-hot master currently owning the slave; 0 when idle.

Function
REQ-009 SHALL treat mN_wen_i/mN_ren_i as single-cycle request strobes, sampled on rising clk_i edges.
REQ-010 SHALL latch addr, wdata and type into a per-master pending slot on a strobe when that slot is empty.
REQ-011 SHALL, if wen and ren are asserted in the same cycle, latch a write only.
REQ-012 SHALL ignore a strobe while that master's slot is pending; the protocol allows one outstanding request per master.
REQ-013 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> IDLE.
REQ-014 IDLE: if any slot is pending, SHALL grant one master, register s_addr_o/s_wdata_o from its slot and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-015 ISSUE: SHALL assert s_wen_o or s_ren_o for exactly one cycle, then go to WAIT, unless s_ack_i is high in this cycle, in which case it SHALL complete.
REQ-016 WAIT: SHALL hold s_addr_o/s_wdata_o stable with strobes low, and SHALL complete on s_ack_i.
REQ-017 Completion SHALL register mN_ack_o=1, mN_rdata_o=s_rdata_i, mN_err_o=s_err_i for the granted master for exactly one cycle, clear its slot, and return to IDLE.
REQ-018 Latency SHALL be 4 cycles from the master strobe to mN_ack_o when the slave acks 1 cycle after its strobe.
REQ-019 SHALL arbitrate round-robin: on simultaneous pending, grant the master not served last; after reset m0 has priority.
REQ-020 A strobe from master A arriving during master B's transaction SHALL be latched and served immediately after, with no bubble beyond the IDLE cycle.
REQ-021 The timeout counter SHALL start at ISSUE entry.
REQ-022 If the timeout counter reaches TMO without s_ack_i, SHALL complete with mN_err_o=1 and mN_rdata_o=0, then return to IDLE.
REQ-023 A late s_ack_i arriving in IDLE SHALL be ignored.
REQ-024 mN_rdata_o SHALL hold its last value between acks.
REQ-025 The non-granted master's ack/err SHALL stay 0.
REQ-026 grant_o SHALL be non-zero only in ISSUE and WAIT.

Reset
REQ-027 On rst_i high, SHALL immediately force the FSM to IDLE and set all outputs, pending slots, timeout counter and round-robin pointer (m0 priority) to 0.
REQ-028 A transaction in flight at reset SHALL be dropped with no ack; a master strobe during reset SHALL be discarded.
REQ-029 The first strobe SHALL be accepted on the first edge after rst_i deasserts.

Structure
REQ-030 A shared package hk_arb_pkg SHALL hold the FSM state enum (IDLE, ISSUE, WAIT), the default TMO and the timeout counter width (16).
REQ-031 Per-master pending storage SHALL be one sub-module, hk_arb_req_slot, instantiated twice; arbitration and FSM stay in the top.

Verification
REQ-032 Bench SHALL cover: m0 write addr 0x30, wdata 0x80; slave acks 1 cycle after strobe -> s_wen_o is a single pulse, m0_ack_o 4 cycles after strobe, m0_err_o=0.
REQ-033 Bench SHALL cover: m0 and m1 read the same cycle; slave returns 0x1 then 0x2 -> m0 is served first with rdata 0x1, m1 next with rdata 0x2, and grant_o goes 01, then 10.
REQ-034 Bench SHALL cover: m1 read with the slave never acking, TMO=16 -> m1_ack_o=1, m1_err_o=1, m1_rdata_o=0 at cycle 16 after ISSUE; a later stray s_ack_i produces no ack.
REQ-035 Bench SHALL cover: m0 issues 3 back-to-back requests while m1 stays pending -> strict alternation m0, m1, m0; no starvation.
REQ-036 Bench SHALL cover: rst_i pulsed while in WAIT -> outputs 0 asynchronously, no ack, and the next m1 strobe completes normally.
REQ-037 Bench SHALL cover: m0 wen and ren together with wdata 0xA5 -> s_wen_o=1, s_ren_o=0, s_wdata_o=0xA5.
